// File: rtl/vld_dff_pipe_pkg.sv
// -----------------------------------------------------------------------------
// vld_dff_pipe_pkg
// Shared definitions for the valid/ready register pipeline.
//   CntW(depth) : width of an occupancy counter that has to hold 0..depth.
//   stage_t     : one pipeline stage (valid bit + data word). The data field
//                 has the pipe's default 32-bit width.
// Optional feature macro used by the pipeline: ZION_VLD_PIPE_BUBBLE_COLLAPSE_EN
// -----------------------------------------------------------------------------
package vld_dff_pipe_pkg;

  localparam int STAGE_DAT_W = 32;

  typedef struct packed {
    logic                   vld;
    logic [STAGE_DAT_W-1:0] dat;
  } stage_t;

  // Counter width for 0..depth inclusive; never narrower than one bit.
  function automatic int CntW(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vld_dff_pipe_stage.sv
// -----------------------------------------------------------------------------
// vld_dff_pipe_stage
// One stage of the pipeline: an enabled data register plus its valid bit.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset (vld=0, dat=INI_DATA)
//   adv    in   stage advances this cycle (loads in_vld / in_dat)
//   flush  in   clear the valid bit at the next edge, data untouched
//   in_vld in   valid bit arriving from the upstream stage
//   in_dat in   data arriving from the upstream stage [WIDTH]
//   vld    out  stage valid register
//   dat    out  stage data register [WIDTH]
// -----------------------------------------------------------------------------
module vld_dff_pipe_stage
  import vld_dff_pipe_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      dat <= INI_DATA;
    end else begin
      // Flush wins over an advance and leaves the data register alone.
      if (flush) begin
        vld <= 1'b0;
      end else if (adv) begin
        vld <= in_vld;
        dat <= in_dat;
      end
    end
  end

endmodule

// File: rtl/vld_dff_pipe.sv
// -----------------------------------------------------------------------------
// vld_dff_pipe
// DEPTH-stage register pipeline with valid/ready handshake on both sides,
// synchronous flush and an occupancy count.
// Parameters: WIDTH (data bits), DEPTH (stages), INI_DATA (reset data value).
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   iVld   in   upstream data valid
//   oRdy   out  upstream may transfer this cycle (combinational)
//   iDat   in   upstream data [WIDTH]
//   iFlush in   synchronous flush: drops all valid words at the next edge
//   oVld   out  last stage holds valid data (registered)
//   iRdy   in   downstream accepts this cycle
//   oDat   out  last stage data register [WIDTH]
//   oCnt   out  number of valid stages [CntW(DEPTH)]
// Build option ZION_VLD_PIPE_BUBBLE_COLLAPSE_EN:
//   defined   -> each stage advances on its own, squeezing out bubbles while
//                the output is stalled.
//   undefined -> single global shift enable en = iRdy | !oVld.
// -----------------------------------------------------------------------------
module vld_dff_pipe
  import vld_dff_pipe_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iVld,
  output logic                      oRdy,
  input  logic [WIDTH-1:0]          iDat,
  input  logic                      iFlush,
  output logic                      oVld,
  input  logic                      iRdy,
  output logic [WIDTH-1:0]          oDat,
  output logic [CntW(DEPTH)-1:0]    oCnt
);

  localparam int CW = CntW(DEPTH);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [CW-1:0]    cnt;

`ifdef ZION_VLD_PIPE_BUBBLE_COLLAPSE_EN
  // A stage may take new content when it is empty or when its own content
  // moves on; evaluated from the output end back towards the input.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = !vld[DEPTH-1] | iRdy;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !vld[k] | adv[k+1];
    end
  end

  assign oRdy = adv[0] & !iFlush;
`else
  logic en;

  // Whole pipe shifts together whenever the output word leaves or is empty.
  assign en   = iRdy | !vld[DEPTH-1];
  assign adv  = {DEPTH{en}};
  assign oRdy = en & !iFlush;
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             in_vld;
    logic [WIDTH-1:0] in_dat;

    if (gi == 0) begin : g_head
      assign in_vld = iVld & oRdy;
      assign in_dat = iDat;
    end else begin : g_body
      assign in_vld = vld[gi-1];
      assign in_dat = dat[gi-1];
    end

    vld_dff_pipe_stage #(
      .WIDTH    (WIDTH),
      .INI_DATA (INI_DATA)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv[gi]),
      .flush  (iFlush),
      .in_vld (in_vld),
      .in_dat (in_dat),
      .vld    (vld[gi]),
      .dat    (dat[gi])
    );
  end

  // Occupancy is derived from the valid registers, so it is exact at all
  // times including during reset.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CW'(vld[k]);
    end
  end

  assign oVld = vld[DEPTH-1];
  assign oDat = dat[DEPTH-1];
  assign oCnt = cnt;

endmodule
